button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
//
// PURPOSE
//  Two-channel push-button front end that generates the A/B operands for the
//  basic-gates stage. Each raw button is synchronised to clk, debounced and
//  edge-detected, and drives a toggle flip-flop. Outputs op_a/op_b connect
//  directly to the gates block inputs; press pulses and levels are exported
//  for LEDs and bench observation.
//
// PARAMETERS
//  DEBOUNCE_CYCLES  1000  consecutive stable clk cycles required to accept a new level (>=1)
//  CNT_W            $clog2(DEBOUNCE_CYCLES+1)  debounce counter width (derived, localparam)
//
// PORTS
//  clk          in   1  single system clock, all logic on rising edge
//  rst          in   1  synchronous, active-high reset
//  btn_raw      in   2  asynchronous button inputs, bit0 -> A, bit1 -> B
//  clr_toggle   in   1  synchronous clear of both toggle registers
//  btn_level    out  2  debounced button level
//  btn_press    out  2  one-cycle pulse on each debounced 0->1 transition
//  op_a         out  1  toggle state of channel 0, feeds gates input A
//  op_b         out  1  toggle state of channel 1, feeds gates input B
//
// BEHAVIOUR
//  - Reset (rst=1 at posedge): sync FFs, counters, btn_level, btn_press, op_a, op_b all 0.
//    Reset mid-debounce discards the count; no press pulse is produced by reset.
//  - Sync: 2-FF chain per channel; sync_q = btn_raw delayed 2 cycles.
//  - Debounce, per channel (state = stable level + counter):
//      sync_q == btn_level       -> cnt <= 0 (any glitch restarts the count)
//      sync_q != btn_level and cnt <  DEBOUNCE_CYCLES-1 -> cnt <= cnt+1
//      sync_q != btn_level and cnt == DEBOUNCE_CYCLES-1 -> btn_level <= sync_q, cnt <= 0
//    The counter never wraps; it saturates at the accept condition.
//  - Latency: btn_raw edge held steady -> btn_level changes DEBOUNCE_CYCLES+2 cycles later.
//  - btn_press[i] = 1 for exactly one cycle, registered in the same cycle btn_level[i]
//    goes 0->1. No pulse on 1->0.
//  - Toggle: on btn_press[i], op bit inverts. clr_toggle has priority over press:
//    simultaneous clr_toggle and press -> op = 0. Both channels are independent;
//    simultaneous presses toggle both in the same cycle.
//  - Raw input bouncing faster than DEBOUNCE_CYCLES produces no level change, no pulse.
//  - DEBOUNCE_CYCLES=1: level follows sync_q with one extra cycle (no filtering).
//
// STRUCTURE
//  - Shared header file (`include): default DEBOUNCE_CYCLES, channel count (2),
//    channel index constants CH_A=0, CH_B=1.
//  - One sub-module, debounce_channel: sync + counter + level + press for one bit,
//    instantiated twice. Toggle registers and clr_toggle stay in the top module.
//
// TESTING  (bench uses DEBOUNCE_CYCLES=4)
//  1 rst=1 3 cycles, btn_raw=2'b11 -> all outputs 0 during and 1 cycle after reset.
//  2 btn_raw[0] 0->1 held -> btn_level[0]=1 and btn_press[0]=1 exactly 6 cycles later,
//    press low the next cycle, op_a=1. Release and hold -> level 0 after 6, op_a stays 1.
//  3 btn_raw[1] bounces 1,0,1,0,1 on consecutive cycles, then holds 1 -> single press,
//    op_b toggles once (0->1), level rises 6 cycles after the final edge.
//  4 Both buttons pressed in the same cycle -> both presses in the same cycle,
//    op_a and op_b both invert.
//  5 clr_toggle asserted in the cycle of a press with op_a=1 -> op_a=0 (clear wins).
//  6 rst asserted after 3 stable cycles of a press -> no pulse. After release, re-press
//    needs the full 6 cycles.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared constants for the push-button front end: default debounce length,
// channel count and the channel index assignment (bit0 -> A, bit1 -> B).
package button_conditioner_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000;
  localparam int NUM_CH                  = 2;
  localparam int CH_A                    = 0;
  localparam int CH_B                    = 1;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: 2-FF synchroniser, stability counter, debounced level
// and a one-cycle press pulse on each accepted 0->1 transition.
//
// The counter only runs while the synchronised input disagrees with the
// accepted level. Any agreement (a glitch back to the old level) restarts it.
// On reaching DEBOUNCE_CYCLES-1 the new level is accepted and the counter is
// cleared, so it never wraps. Total latency from a steady raw edge to the level
// change is DEBOUNCE_CYCLES+2 clocks.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_q;
  logic [CNT_W-1:0] cnt;

  // Synchronise, count stable cycles, accept the new level and pulse on rising acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      cnt       <= '0;
      level     <= 1'b0;
      press     <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
      press     <= 1'b0;
      if (sync_q == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_q;
        press <= sync_q;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Two-channel push-button front end producing the A/B operands for the
// basic-gates stage. Each debounced press flips a toggle register; clr_toggle
// clears both toggles and wins over a simultaneous press.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] btn_raw,
  input  logic              clr_toggle,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] btn_press,
  output logic              op_a,
  output logic              op_b
);

  logic [NUM_CH-1:0] toggle_q;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_a (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_raw[CH_A]),
    .level(btn_level[CH_A]),
    .press(btn_press[CH_A])
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_b (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_raw[CH_B]),
    .level(btn_level[CH_B]),
    .press(btn_press[CH_B])
  );

  // Toggle registers: independent per channel, clear has priority over press
  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_q <= '0;
    end else if (clr_toggle) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_q ^ btn_press;
    end
  end

  assign op_a = toggle_q[CH_A];
  assign op_b = toggle_q[CH_B];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4 (level changes
// 6 clocks after a steady raw edge). Inputs change 1 time unit after a rising
// edge; outputs are sampled at the same point, away from the active edge.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] btn_raw = 2'b00;
  logic       clr_toggle = 1'b0;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic       op_a;
  logic       op_b;

  int n_checked = 0;
  int n_failed  = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .clr_toggle(clr_toggle),
    .btn_level (btn_level),
    .btn_press (btn_press),
    .op_a      (op_a),
    .op_b      (op_b)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checked++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Packs every output into one byte: {level, press, op_b, op_a}
  function automatic logic [7:0] outs();
    return {2'b00, btn_level, btn_press, op_b, op_a};
  endfunction

  initial begin
    // 1: reset with both buttons held, then one cycle after
    rst = 1'b1;
    btn_raw = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("reset_outs", outs(), 8'h00);
    end
    rst = 1'b0;
    btn_raw = 2'b00;
    tick();
    check_eq("post_reset_outs", outs(), 8'h00);
    tick(10);
    check_eq("idle_outs", outs(), 8'h00);

    // 2: press A, 6-cycle latency, one-cycle pulse, toggle
    btn_raw = 2'b01;
    tick(5);
    check_eq("a_level_before", btn_level, 2'b00);
    check_eq("a_press_before", btn_press, 2'b00);
    tick();
    check_eq("a_level_rise", btn_level, 2'b01);
    check_eq("a_press_pulse", btn_press, 2'b01);
    tick();
    check_eq("a_press_drop", btn_press, 2'b00);
    check_eq("a_op_a_set", op_a, 1'b1);
    btn_raw = 2'b00;
    tick(5);
    check_eq("a_rel_level_before", btn_level, 2'b01);
    tick();
    check_eq("a_rel_level_fall", btn_level, 2'b00);
    check_eq("a_rel_no_press", btn_press, 2'b00);
    tick();
    check_eq("a_rel_op_a_kept", op_a, 1'b1);

    // 3: B bounces 1,0,1,0,1 then holds 1
    btn_raw[1] = 1'b1; tick();
    btn_raw[1] = 1'b0; tick();
    check_eq("b_bounce_level", btn_level[1], 1'b0);
    btn_raw[1] = 1'b1; tick();
    btn_raw[1] = 1'b0; tick();
    check_eq("b_bounce_press", btn_press[1], 1'b0);
    btn_raw[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("b_hold_no_press", {btn_level[1], btn_press[1]}, 2'b00);
    end
    tick();
    check_eq("b_level_rise", btn_level, 2'b10);
    check_eq("b_press_pulse", btn_press, 2'b10);
    tick();
    check_eq("b_press_drop", btn_press, 2'b00);
    check_eq("b_op_b_set", op_b, 1'b1);
    check_eq("b_op_a_kept", op_a, 1'b1);

    // 4: release both, then press both together
    btn_raw = 2'b00;
    tick(8);
    check_eq("both_released", btn_level, 2'b00);
    btn_raw = 2'b11;
    tick(6);
    check_eq("both_press", btn_press, 2'b11);
    check_eq("both_level", btn_level, 2'b11);
    tick();
    check_eq("both_op_a_inv", op_a, 1'b0);
    check_eq("both_op_b_inv", op_b, 1'b0);

    // 5a: clear in the press cycle with op_a=0 keeps op_a at 0
    btn_raw = 2'b00;
    tick(8);
    btn_raw = 2'b01;
    tick(6);
    check_eq("clr_a_press_seen", btn_press, 2'b01);
    clr_toggle = 1'b1;
    tick();
    clr_toggle = 1'b0;
    check_eq("clr_wins_op_a0", op_a, 1'b0);
    // 5b: plain press sets op_a, then press with clear gives 0
    btn_raw = 2'b00;
    tick(8);
    btn_raw = 2'b01;
    tick(7);
    check_eq("plain_press_op_a", op_a, 1'b1);
    btn_raw = 2'b00;
    tick(8);
    btn_raw = 2'b01;
    tick(6);
    clr_toggle = 1'b1;
    tick();
    clr_toggle = 1'b0;
    check_eq("clr_wins_op_a1", op_a, 1'b0);
    tick(3);
    check_eq("clr_stays_op_a", op_a, 1'b0);

    // 6: reset mid-debounce drops the count and makes no pulse
    btn_raw = 2'b00;
    tick(8);
    btn_raw = 2'b01;
    tick(3);
    check_eq("mid_level_low", btn_level, 2'b00);
    rst = 1'b1;
    tick();
    check_eq("mid_reset_outs", outs(), 8'h00);
    rst = 1'b0;
    btn_raw = 2'b00;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("mid_after_rst", outs(), 8'h00);
    end
    btn_raw = 2'b01;
    tick(5);
    check_eq("repress_before", btn_level, 2'b00);
    tick();
    check_eq("repress_level", btn_level, 2'b01);
    check_eq("repress_press", btn_press, 2'b01);
    tick();
    check_eq("repress_op_a", op_a, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checked, n_failed);
    $finish;
  end

endmodule
